x2z_mac_array: RTL and testbench

- Streaming signed multiply-accumulate array: NUM_PE processing elements share one input sample stream.
- For each block of BLOCK_LEN samples, PE k computes z[k] = sum of (+/-) coefficient[k]*x, with the sign selected per sample by sum_diff_sel.
- Parametrised successor of the fixed 8-bit, 4-PE x-to-z array: generalised in width, PE count and block length.
- Adds valid/ready handshakes on both sides, an output holding register, coefficient shadowing and a synchronous clear.

---
 rtl/x2z_mac_array.sv | 117 +++++++++++
 tb/tb_x2z_mac_array.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/x2z_mac_array.sv
// Streaming signed MAC array: NUM_PE lanes accumulate +/- coefficient*x over BLOCK_LEN-sample blocks.
// Optional saturating accumulation is enabled by defining X2Z_MAC_ARRAY_SATURATE_EN.
module x2z_mac_array #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int BLOCK_LEN  = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PE-1:0][COEF_WIDTH-1:0]    coefficient,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                x,
    input  logic                                 sum_diff_sel,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_PE-1:0][ACC_WIDTH-1:0]     z
);
    localparam int CNT_W  = $clog2(BLOCK_LEN);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int WIDE_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and producers hold data stable until the transfer.
    typedef enum logic {ACC, STALL} state_t;

    state_t                             state;
    logic                               run;
    logic [CNT_W-1:0]                   sample_cnt;
    logic [NUM_PE-1:0][COEF_WIDTH-1:0]  coef_shadow;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]   acc;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]   acc_next;
    logic                               at_last;
    logic                               out_fire;
    logic                               stall_req;
    logic                               accept;

    assign at_last   = (sample_cnt == LAST);
    assign out_fire  = out_valid && out_ready;
    // The final sample of a block waits while the previous result is still unclaimed.
    assign stall_req = at_last && out_valid && !out_ready;
    assign in_ready  = run && (state == ACC) && !stall_req;
    assign accept    = in_valid && in_ready && !clear;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        logic signed [COEF_WIDTH-1:0] coef_use;
        logic signed [PROD_W-1:0]     prod;
        logic signed [WIDE_W-1:0]     acc_ext;
        logic signed [WIDE_W-1:0]     term_ext;
        logic signed [WIDE_W-1:0]     sum_wide;
        logic [ACC_WIDTH-1:0]         nxt;

        // First sample of a block uses the live coefficient, the rest use the shadow copy.
        assign coef_use = (sample_cnt == '0) ? coefficient[k] : coef_shadow[k];
        assign prod     = PROD_W'($signed(x)) * PROD_W'(coef_use);
        assign acc_ext  = WIDE_W'($signed(acc[k]));
        assign term_ext = WIDE_W'(prod);
        assign sum_wide = sum_diff_sel ? (acc_ext - term_ext) : (acc_ext + term_ext);

`ifdef X2Z_MAC_ARRAY_SATURATE_EN
        always_comb begin
            nxt = sum_wide[ACC_WIDTH-1:0];
            if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
                nxt = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
`else
        assign nxt = sum_wide[ACC_WIDTH-1:0];
`endif

        assign acc_next[k] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            state       <= ACC;
            sample_cnt  <= '0;
            coef_shadow <= '0;
            acc         <= '0;
            z           <= '0;
            out_valid   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (clear) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (accept) begin
                if (sample_cnt == '0) begin
                    coef_shadow <= coefficient;
                end
                if (at_last) begin
                    z          <= acc_next;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= acc_next;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
            case (state)
                ACC:     if (stall_req && !clear) state <= STALL;
                STALL:   if (clear || out_fire) state <= ACC;
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_x2z_mac_array.sv
// Directed bench for x2z_mac_array (ACC_WIDTH=16) with a queue-based output scoreboard.
module tb_x2z_mac_array;
    localparam int NPE   = 4;
    localparam int ACC_W = 16;
    localparam int W     = NPE * ACC_W;
`ifdef X2Z_MAC_ARRAY_SATURATE_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = -2040;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NPE-1:0][7:0]       coefficient;
    logic                      clear;
    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                x;
    logic                      sum_diff_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic [NPE-1:0][ACC_W-1:0] z;

    logic [W-1:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ov_cycles = 0;

    x2z_mac_array #(
        .DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_PE(NPE), .BLOCK_LEN(8), .ACC_WIDTH(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coefficient(coefficient), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .sum_diff_sel(sum_diff_sel),
        .out_valid(out_valid), .out_ready(out_ready), .z(z)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] lanes(input int a, input int b, input int c, input int d);
        logic [NPE-1:0][ACC_W-1:0] v;
        v[0] = ACC_W'(a);
        v[1] = ACC_W'(b);
        v[2] = ACC_W'(c);
        v[3] = ACC_W'(d);
        return v;
    endfunction

    // drivers
    task automatic set_coef(input int a, input int b, input int c, input int d);
        coefficient[0] = 8'(a);
        coefficient[1] = 8'(b);
        coefficient[2] = 8'(c);
        coefficient[3] = 8'(d);
    endtask

    task automatic send(input logic [7:0] xv, input logic sel);
        int   waits = 0;
        logic took  = 1'b0;
        in_valid = 1'b1;
        x = xv;
        sum_diff_sel = sel;
        while (!took && waits < 100) begin
            @(negedge clk);
            took = in_ready && !clear;
            @(posedge clk);
            #1;
            if (!took) waits++;
        end
        if (!took) begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_out: out_valid=1 z=%0h with empty scoreboard", z);
            end else begin
                check("sb_z", z, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        x = '0;
        sum_diff_sel = 1'b0;
        out_ready = 1'b1;
        set_coef(0, 0, 0, 0);
        #12;
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_z", z, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready_low", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", W'(in_ready), W'(1));

        // alternating sign, coefficient -1 on every lane
        set_coef(-1, -1, -1, -1);
        exp_q.push_back(lanes(4, 4, 4, 4));
        for (int j = 0; j < 8; j++) send(8'(j), 1'(j % 2));
        in_valid = 1'b0;
        @(negedge clk);
        check("alt_pulse_hi", W'(out_valid), W'(1));
        @(negedge clk);
        check("alt_pulse_lo", W'(out_valid), W'(0));
        idle(2);

        // per-lane coefficients, zeroed mid-block (shadow must hold)
        set_coef(1, 2, 3, -1);
        exp_q.push_back(lanes(28, 56, 84, -28));
        for (int j = 0; j < 8; j++) begin
            send(8'(j), 1'b0);
            if (j == 1) set_coef(0, 0, 0, 0);
        end
        idle(3);

        // backpressure across two back-to-back blocks
        out_ready = 1'b0;
        set_coef(1, 1, 1, 1);
        exp_q.push_back(lanes(8, 8, 8, 8));
        for (int j = 0; j < 8; j++) send(8'd1, 1'b0);
        exp_q.push_back(lanes(16, 16, 16, 16));
        for (int j = 0; j < 7; j++) send(8'd2, 1'b0);
        @(negedge clk);
        check("bp_in_ready_low", W'(in_ready), W'(0));
        check("bp_z_hold", z, lanes(8, 8, 8, 8));
        check("bp_out_valid", W'(out_valid), W'(1));
        repeat (3) @(negedge clk);
        check("bp_still_stalled", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_stall_during_release", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_last_accept_next_cycle", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_block2_valid", W'(out_valid), W'(1));
        check("bp_block2_z", z, lanes(16, 16, 16, 16));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);

        // overflow: wrap or saturate at 16 bits
        set_coef(127, 127, 127, 127);
        exp_q.push_back(lanes(OVF_EXP, OVF_EXP, OVF_EXP, OVF_EXP));
        for (int j = 0; j < 8; j++) send(8'd127, 1'b0);
        idle(3);

        // clear aborts a partial block; a sample presented with clear is dropped
        ov_cycles = 0;
        set_coef(1, 1, 1, 1);
        for (int j = 0; j < 3; j++) send(8'd5, 1'b0);
        clear = 1'b1;
        in_valid = 1'b1;
        x = 8'd9;
        @(negedge clk);
        check("clr_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        exp_q.push_back(lanes(8, 8, 8, 8));
        for (int j = 0; j < 8; j++) send(8'd1, 1'b0);
        idle(4);
        check("clr_one_pulse", W'(ov_cycles), W'(1));

        // asynchronous reset with a pending output and a half-filled block
        out_ready = 1'b0;
        for (int j = 0; j < 12; j++) send(8'd1, 1'b0);
        idle(1);
        @(negedge clk);
        check("arst_pre_valid", W'(out_valid), W'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", W'(out_valid), W'(0));
        check("arst_z", z, '0);
        check("arst_in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_coef(1, 2, 3, -1);
        exp_q.push_back(lanes(6, 12, 18, -6));
        for (int j = 0; j < 8; j++) send(8'(j + 1), (j >= 6));
        idle(1);

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 50) begin
                @(posedge clk);
                guard++;
            end
        end
        check("sb_drain", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
